// File: rtl/cache_pkg.sv
// Shared types and constants for the cacheline-to-burst adaptor.
package cache_pkg;

  localparam int unsigned BEAT_W   = 64;
  localparam int unsigned LINE_W   = 256;
  localparam int unsigned OFFSET_W = 5;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } burst_state_t;

  // Align a byte address down to the start of its cacheline.
  function automatic logic [31:0] line_base(input logic [31:0] addr);
    return {addr[31:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/cacheline_burst_adaptor_if.sv
// Cache-side line handshake plus memory-side burst signals of the adaptor.
interface cacheline_burst_adaptor_if #(
  parameter int unsigned BEATS = 4
);
  localparam int unsigned LINE_BITS = cache_pkg::BEAT_W * BEATS;

  logic [31:0]                   line_addr_i;
  logic                          line_read_i;
  logic                          line_write_i;
  logic [LINE_BITS-1:0]          line_wdata_i;
  logic [LINE_BITS-1:0]          line_rdata_o;
  logic                          line_resp_o;
  logic [31:0]                   burst_addr_o;
  logic                          burst_read_o;
  logic                          burst_write_o;
  logic [cache_pkg::BEAT_W-1:0]  burst_wdata_o;
  logic [cache_pkg::BEAT_W-1:0]  burst_rdata_i;
  logic                          burst_resp_i;
  logic                          err_o;

  modport slave (
    input  line_addr_i, line_read_i, line_write_i, line_wdata_i,
    input  burst_rdata_i, burst_resp_i,
    output line_rdata_o, line_resp_o, burst_addr_o, burst_read_o,
    output burst_write_o, burst_wdata_o, err_o
  );

  modport master (
    output line_addr_i, line_read_i, line_write_i, line_wdata_i,
    output burst_rdata_i, burst_resp_i,
    input  line_rdata_o, line_resp_o, burst_addr_o, burst_read_o,
    input  burst_write_o, burst_wdata_o, err_o
  );

endinterface

// File: rtl/burst_watchdog.sv
// Idle-cycle counter between burst beats; flags the cycle that reaches the limit.
module burst_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q;

  // Expiry fires on the TIMEOUT_CYCLES-th consecutive idle cycle.
  assign expired_c = en && !clr && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en && !expired_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cacheline_burst_adaptor.sv
// Splits cacheline reads/writes into BEATS x 64-bit bursts and reassembles read lines.
// Optional stall watchdog enabled by defining BURST_WATCHDOG_EN.
module cacheline_burst_adaptor
  import cache_pkg::*;
#(
  parameter int unsigned BEATS          = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                      clk,
  input  logic                      rst,
  cacheline_burst_adaptor_if.slave  bus
);

  localparam int unsigned LINE_BITS = BEAT_W * BEATS;
  localparam int unsigned CNT_W     = $clog2(BEATS);

  burst_state_t           state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_nxt;
  logic [31:0]            addr_q, addr_d;
  logic [LINE_BITS-1:0]   buf_q, buf_d;
  logic [BEAT_W-1:0]      wdata_q, wdata_d;
  logic                   rd_q, rd_d;
  logic                   wr_q, wr_d;
  logic                   resp_q, resp_d;
  logic                   err_q, err_d;
  logic                   wd_expired_c;
  logic                   last_beat_c;

`ifdef BURST_WATCHDOG_EN
  logic wd_clr_c;
  logic wd_en_c;

  // Counter restarts on every accepted beat and while waiting in IDLE.
  assign wd_en_c  = (state_q == RD_BURST) || (state_q == WR_BURST);
  assign wd_clr_c = (state_q == IDLE) || bus.burst_resp_i;

  burst_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .clr       (wd_clr_c),
    .en        (wd_en_c),
    .expired_c (wd_expired_c)
  );
`else
  assign wd_expired_c = 1'b0;
`endif

  assign cnt_nxt     = cnt_q + CNT_W'(1);
  assign last_beat_c = (cnt_q == CNT_W'(BEATS - 1));

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      wdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    wdata_d = wdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    resp_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.line_read_i) begin
          addr_d  = line_base(bus.line_addr_i);
          cnt_d   = '0;
          rd_d    = 1'b1;
          state_d = RD_BURST;
        end else if (bus.line_write_i) begin
          addr_d  = line_base(bus.line_addr_i);
          buf_d   = bus.line_wdata_i;
          wdata_d = bus.line_wdata_i[BEAT_W-1:0];
          cnt_d   = '0;
          wr_d    = 1'b1;
          state_d = WR_BURST;
        end
      end

      RD_BURST: begin
        rd_d = 1'b1;
        if (bus.burst_resp_i) begin
          buf_d[BEAT_W*cnt_q +: BEAT_W] = bus.burst_rdata_i;
          cnt_d = cnt_nxt;
          if (last_beat_c) begin
            rd_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end
        end else if (wd_expired_c) begin
          cnt_d   = '0;
          rd_d    = 1'b0;
          resp_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      WR_BURST: begin
        wr_d = 1'b1;
        if (bus.burst_resp_i) begin
          cnt_d = cnt_nxt;
          if (last_beat_c) begin
            wr_d    = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end else begin
            wdata_d = buf_q[BEAT_W*cnt_nxt +: BEAT_W];
          end
        end else if (wd_expired_c) begin
          cnt_d   = '0;
          wr_d    = 1'b0;
          resp_d  = 1'b1;
          err_d   = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.line_rdata_o  = buf_q;
  assign bus.line_resp_o   = resp_q;
  assign bus.burst_addr_o  = addr_q;
  assign bus.burst_read_o  = rd_q;
  assign bus.burst_write_o = wr_q;
  assign bus.burst_wdata_o = wdata_q;
  assign bus.err_o         = err_q;

endmodule
